// File: rtl/logic_unit_arbiter.sv
// Two-requester front end for a shared external 4/8-bit logic unit.
// Picks a winner (round-robin or fixed priority), drives the unit, and returns its result with a done pulse.
module logic_unit_arbiter #(
  parameter bit          RR_EN = 1'b1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [3:0]       a0,
  input  logic [3:0]       a1,
  input  logic [3:0]       b0,
  input  logic [3:0]       b1,
  input  logic [7:0]       c0,
  input  logic [7:0]       c1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [7:0]       res,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt,
  output logic [3:0]       lu_a,
  output logic [3:0]       lu_b,
  output logic [7:0]       lu_c,
  output logic [1:0]       lu_sw,
  input  logic [7:0]       lu_f
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state_q;
  logic             ptr_q;
  logic             win_q;
  logic [1:0]       gnt_q;
  logic [1:0]       done_q;
  logic [7:0]       res_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       lu_a_q;
  logic [3:0]       lu_b_q;
  logic [7:0]       lu_c_q;
  logic [1:0]       lu_sw_q;

  logic             win_d;
  logic [3:0]       a_d;
  logic [3:0]       b_d;
  logic [7:0]       c_d;
  logic [1:0]       sw_d;

  // Winner: pointer side if it is requesting, else the other (RR); requester 0 first otherwise.
  always_comb begin
    win_d = 1'b0;
    if (RR_EN) begin
      win_d = req[ptr_q] ? ptr_q : ~ptr_q;
    end else begin
      win_d = ~req[0];
    end
    a_d  = win_d ? a1  : a0;
    b_d  = win_d ? b1  : b0;
    c_d  = win_d ? c1  : c0;
    sw_d = win_d ? op1 : op0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      lu_a_q  <= '0;
      lu_b_q  <= '0;
      lu_c_q  <= '0;
      lu_sw_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            lu_a_q  <= a_d;
            lu_b_q  <= b_d;
            lu_c_q  <= c_d;
            lu_sw_q <= sw_d;
            gnt_q   <= {win_d, ~win_d};
            win_q   <= win_d;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
            if (RR_EN) ptr_q <= ~win_d;
          end
        end
        ISSUE: begin
          res_q   <= lu_f;
          done_q  <= {win_q, ~win_q};
          gnt_q   <= '0;
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          done_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign res    = res_q;
  assign busy   = busy_q;
  assign op_cnt = cnt_q;
  assign lu_a   = lu_a_q;
  assign lu_b   = lu_b_q;
  assign lu_c   = lu_c_q;
  assign lu_sw  = lu_sw_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: a round-robin/8-bit-counter instance and a fixed-priority/2-bit-counter
// instance, each driving a behavioural logic unit, checked against a transaction-level model.
module tb_logic_unit_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_s [2];
  logic [1:0] req_s   [2];
  logic [1:0] op0_s   [2];
  logic [1:0] op1_s   [2];
  logic [3:0] a0_s    [2];
  logic [3:0] a1_s    [2];
  logic [3:0] b0_s    [2];
  logic [3:0] b1_s    [2];
  logic [7:0] c0_s    [2];
  logic [7:0] c1_s    [2];
  logic [1:0] gnt_s   [2];
  logic [1:0] done_s  [2];
  logic [7:0] res_s   [2];
  logic       busy_s  [2];
  logic [3:0] lu_a_s  [2];
  logic [3:0] lu_b_s  [2];
  logic [7:0] lu_c_s  [2];
  logic [1:0] lu_sw_s [2];
  logic [7:0] lu_f_s  [2];
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  int total = 0;
  int bad   = 0;
  int m_cnt [2];
  int cnt_max [2] = '{255, 3};
  int m_ptr;

  logic_unit_arbiter #(.RR_EN(1'b1), .CNT_W(8)) u_rr (
    .clk(clk), .rst_n(rst_n_s[0]), .req(req_s[0]),
    .op0(op0_s[0]), .op1(op1_s[0]), .a0(a0_s[0]), .a1(a1_s[0]),
    .b0(b0_s[0]), .b1(b1_s[0]), .c0(c0_s[0]), .c1(c1_s[0]),
    .gnt(gnt_s[0]), .done(done_s[0]), .res(res_s[0]), .busy(busy_s[0]), .op_cnt(cnt0),
    .lu_a(lu_a_s[0]), .lu_b(lu_b_s[0]), .lu_c(lu_c_s[0]), .lu_sw(lu_sw_s[0]), .lu_f(lu_f_s[0])
  );

  logic_unit_arbiter #(.RR_EN(1'b0), .CNT_W(2)) u_fx (
    .clk(clk), .rst_n(rst_n_s[1]), .req(req_s[1]),
    .op0(op0_s[1]), .op1(op1_s[1]), .a0(a0_s[1]), .a1(a1_s[1]),
    .b0(b0_s[1]), .b1(b1_s[1]), .c0(c0_s[1]), .c1(c1_s[1]),
    .gnt(gnt_s[1]), .done(done_s[1]), .res(res_s[1]), .busy(busy_s[1]), .op_cnt(cnt1),
    .lu_a(lu_a_s[1]), .lu_b(lu_b_s[1]), .lu_c(lu_c_s[1]), .lu_sw(lu_sw_s[1]), .lu_f(lu_f_s[1])
  );

  // External logic unit, purely combinational.
  function automatic logic [7:0] unit_f(input logic [1:0] sw, input logic [3:0] a, input logic [3:0] b,
                                        input logic [7:0] c);
    case (sw)
      2'b00:   unit_f = {4'h0, a & b};
      2'b01:   unit_f = {4'h0, a | b};
      2'b10:   unit_f = {4'h0, a ^ b};
      default: unit_f = ~c;
    endcase
  endfunction

  assign lu_f_s[0] = unit_f(lu_sw_s[0], lu_a_s[0], lu_b_s[0], lu_c_s[0]);
  assign lu_f_s[1] = unit_f(lu_sw_s[1], lu_a_s[1], lu_b_s[1], lu_c_s[1]);

  // Expected result computed bit by bit from the operation's truth rule.
  function automatic logic [7:0] ref_res(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                                         input logic [7:0] c);
    logic [7:0] r;
    r = '0;
    if (op == 2'b11) begin
      for (int i = 0; i < 8; i++) r[i] = (c[i] == 1'b0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        int s;
        s = int'(a[i]) + int'(b[i]);
        r[i] = (op == 2'b00) ? (s == 2) : (op == 2'b01) ? (s >= 1) : (s == 1);
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] get_cnt(input int k);
    return (k == 0) ? 32'(cnt0) : 32'(cnt1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_ops(input int k);
    op0_s[k] = 2'($urandom_range(0, 3));
    op1_s[k] = 2'($urandom_range(0, 3));
    a0_s[k]  = 4'($urandom);
    a1_s[k]  = 4'($urandom);
    b0_s[k]  = 4'($urandom);
    b1_s[k]  = 4'($urandom);
    c0_s[k]  = 8'($urandom);
    c1_s[k]  = 8'($urandom);
  endtask

  task automatic do_reset(input int k);
    @(negedge clk);
    rst_n_s[k] = 1'b0;
    req_s[k]   = 2'b00;
    @(negedge clk);
    rst_n_s[k] = 1'b1;
    m_cnt[k]   = 0;
    if (k == 0) m_ptr = 0;
  endtask

  // One full transaction, starting with the DUT idle at the next rising edge and req already driven.
  task automatic run_op(input int k, input bit change_a, output int wo);
    int         w;
    logic [1:0] r, op;
    logic [3:0] a, b;
    logic [7:0] c, e;
    r = req_s[k];
    if (k == 0) w = r[m_ptr] ? m_ptr : 1 - m_ptr;
    else        w = r[0] ? 0 : 1;
    op = (w == 1) ? op1_s[k] : op0_s[k];
    a  = (w == 1) ? a1_s[k]  : a0_s[k];
    b  = (w == 1) ? b1_s[k]  : b0_s[k];
    c  = (w == 1) ? c1_s[k]  : c0_s[k];
    e  = ref_res(op, a, b, c);

    @(negedge clk);
    wo = gnt_s[k][1] ? 1 : 0;
    chk("gnt",        32'(gnt_s[k]),  32'(1) << w);
    chk("busy_issue", 32'(busy_s[k]), 32'd1);
    chk("done_issue", 32'(done_s[k]), 32'd0);
    chk("lu_a",       32'(lu_a_s[k]), 32'(a));
    chk("lu_b",       32'(lu_b_s[k]), 32'(b));
    chk("lu_c",       32'(lu_c_s[k]), 32'(c));
    chk("lu_sw",      32'(lu_sw_s[k]), 32'(op));
    req_s[k][w] = 1'b0;
    if (change_a) begin
      a0_s[k] = ~a0_s[k];
      a1_s[k] = ~a1_s[k];
    end
    if (m_cnt[k] < cnt_max[k]) m_cnt[k]++;
    if (k == 0) m_ptr = 1 - w;

    @(negedge clk);
    chk("done",      32'(done_s[k]), 32'(1) << w);
    chk("gnt_clr",   32'(gnt_s[k]),  32'd0);
    chk("res",       32'(res_s[k]),  32'(e));
    chk("op_cnt",    get_cnt(k),     32'(m_cnt[k]));
    chk("busy_resp", 32'(busy_s[k]), 32'd1);

    @(negedge clk);
    chk("done_clr",  32'(done_s[k]), 32'd0);
    chk("busy_idle", 32'(busy_s[k]), 32'd0);
    chk("res_hold",  32'(res_s[k]),  32'(e));
  endtask

  initial begin
    int w;
    // T1: reset with random inputs
    for (int k = 0; k < 2; k++) begin
      rst_n_s[k] = 1'b0;
      req_s[k]   = 2'($urandom);
      rand_ops(k);
      m_cnt[k]   = 0;
    end
    m_ptr = 0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        req_s[k] = 2'($urandom);
        rand_ops(k);
      end
    end
    for (int k = 0; k < 2; k++) begin
      chk("rst_gnt",  32'(gnt_s[k]),   32'd0);
      chk("rst_done", 32'(done_s[k]),  32'd0);
      chk("rst_res",  32'(res_s[k]),   32'd0);
      chk("rst_busy", 32'(busy_s[k]),  32'd0);
      chk("rst_cnt",  get_cnt(k),      32'd0);
      chk("rst_lu",   {lu_a_s[k], lu_b_s[k], lu_c_s[k], lu_sw_s[k]}, 32'd0);
      req_s[k]   = 2'b00;
      rst_n_s[k] = 1'b1;
    end

    // T2: single AND op
    op0_s[0] = 2'b00; a0_s[0] = 4'hC; b0_s[0] = 4'hA; req_s[0] = 2'b01;
    run_op(0, 1'b0, w);
    chk("t2_res", 32'(res_s[0]), 32'h08);
    chk("t2_cnt", get_cnt(0),   32'd1);

    // T3: contention right after reset
    do_reset(0);
    op0_s[0] = 2'b10; a0_s[0] = 4'hF; b0_s[0] = 4'h5;
    op1_s[0] = 2'b11; c1_s[0] = 8'h3C;
    req_s[0] = 2'b11;
    run_op(0, 1'b0, w);
    chk("t3_first", 32'(w), 32'd0);
    chk("t3_res0",  32'(res_s[0]), 32'h0A);
    run_op(0, 1'b0, w);
    chk("t3_second", 32'(w), 32'd1);
    chk("t3_res1",   32'(res_s[0]), 32'hC3);

    // T4: fairness with immediate re-requests
    rand_ops(0);
    req_s[0] = 2'b11;
    for (int i = 0; i < 6; i++) begin
      run_op(0, 1'b0, w);
      chk("rr_order", 32'(w), 32'(i % 2));
      req_s[0][w] = 1'b1;
      rand_ops(0);
    end
    req_s[0] = 2'b00;
    rand_ops(1);
    req_s[1] = 2'b11;
    for (int i = 0; i < 6; i++) begin
      run_op(1, 1'b0, w);
      chk("fixed_order", 32'(w), 32'd0);
      req_s[1][w] = 1'b1;
      rand_ops(1);
    end
    req_s[1] = 2'b00;

    // T5: reset while in ISSUE
    rand_ops(0);
    req_s[0] = 2'b01;
    @(negedge clk);
    chk("t5_busy", 32'(busy_s[0]), 32'd1);
    rst_n_s[0] = 1'b0;
    req_s[0]   = 2'b00;
    @(negedge clk);
    rst_n_s[0] = 1'b1;
    m_cnt[0] = 0;
    m_ptr    = 0;
    chk("t5_done", 32'(done_s[0]), 32'd0);
    chk("t5_busy0", 32'(busy_s[0]), 32'd0);
    chk("t5_cnt",  get_cnt(0),     32'd0);
    @(negedge clk);
    chk("t5_nodone", 32'(done_s[0]), 32'd0);
    rand_ops(0);
    req_s[0] = 2'b01;
    run_op(0, 1'b0, w);
    chk("t5_cnt1", get_cnt(0), 32'd1);

    // T6: counter saturation and operand change in flight
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      rand_ops(1);
      if (i == 0) begin
        op0_s[1] = 2'b00; a0_s[1] = 4'hF; b0_s[1] = 4'h6;
      end
      req_s[1] = 2'b01;
      run_op(1, 1'b1, w);
      chk("sat_cnt", get_cnt(1), (i >= 2) ? 32'd3 : 32'(i + 1));
      if (i == 0) chk("t6_res", 32'(res_s[1]), 32'h06);
    end

    // Random traffic on the round-robin instance
    for (int i = 0; i < 24; i++) begin
      rand_ops(0);
      req_s[0] = 2'($urandom_range(1, 3));
      run_op(0, 1'($urandom), w);
    end
    req_s[0] = 2'b00;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
